password_lock_ctrl: RTL and testbench



---
 rtl/password_lock_ctrl.sv | 129 ++++++++++++
 tb/tb_password_lock_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/password_lock_ctrl.sv
// Password lock controller: stores a password, handles unlock/set commands over a
// valid/ready port, counts consecutive failures and holds a timed lockout.
module password_lock_ctrl #(
  parameter int                    PASS_WIDTH     = 32,
  parameter int                    MAX_TRIES      = 3,
  parameter int                    LOCKOUT_CYCLES = 16,
  parameter logic [PASS_WIDTH-1:0] RESET_PASS     = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_op,
  input  logic [PASS_WIDTH-1:0]            cmd_data,
  input  logic                             relock,
  output logic                             unlocked,
  output logic                             locked_out,
  output logic                             resp_valid,
  output logic                             resp_ok,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

  localparam int              FW         = $clog2(MAX_TRIES + 1);
  localparam int              TW         = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [FW-1:0]   FAIL_MAX   = FW'(MAX_TRIES);
  localparam logic [TW-1:0]   TIMER_LOAD = TW'(LOCKOUT_CYCLES);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(1);

  typedef enum logic [1:0] {
    S_LOCKED,
    S_UNLOCKED,
    S_LOCKOUT
  } state_t;

  state_t                  state_q;
  logic [PASS_WIDTH-1:0]   pass_q;
  logic [TW-1:0]           timer_q;
  logic [FW-1:0]           fail_q;
  logic                    unlocked_q;
  logic                    locked_out_q;
  logic                    resp_valid_q;
  logic                    resp_ok_q;

  logic                    accept;
  logic                    match;
  logic [FW-1:0]           fail_d;

  assign cmd_ready = (state_q != S_LOCKOUT);
  assign accept    = cmd_valid && cmd_ready;
  assign match     = (cmd_data == pass_q);
  // Saturating increment so the counter can never wrap.
  assign fail_d    = (fail_q == FAIL_MAX) ? fail_q : fail_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LOCKED;
      pass_q       <= RESET_PASS;
      timer_q      <= '0;
      fail_q       <= '0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      case (state_q)
        S_LOCKED: begin
          if (accept) begin
            resp_valid_q <= 1'b1;
            // A set while locked is rejected and leaves everything untouched.
            if (!cmd_op) begin
              if (match) begin
                state_q    <= S_UNLOCKED;
                unlocked_q <= 1'b1;
                fail_q     <= '0;
                resp_ok_q  <= 1'b1;
              end else begin
                fail_q <= fail_d;
                if (fail_d == FAIL_MAX) begin
                  state_q      <= S_LOCKOUT;
                  locked_out_q <= 1'b1;
                  timer_q      <= TIMER_LOAD;
                end
              end
            end
          end
        end
        S_UNLOCKED: begin
          if (accept) begin
            resp_valid_q <= 1'b1;
            if (cmd_op) begin
              pass_q    <= cmd_data;
              resp_ok_q <= 1'b1;
            end else begin
              resp_ok_q <= match;
            end
          end
          if (relock) begin
            state_q    <= S_LOCKED;
            unlocked_q <= 1'b0;
          end
        end
        S_LOCKOUT: begin
          if (timer_q == TIMER_LAST) begin
            state_q      <= S_LOCKED;
            locked_out_q <= 1'b0;
            fail_q       <= '0;
            timer_q      <= '0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          state_q      <= S_LOCKED;
          unlocked_q   <= 1'b0;
          locked_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign unlocked   = unlocked_q;
  assign locked_out = locked_out_q;
  assign resp_valid = resp_valid_q;
  assign resp_ok    = resp_ok_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_password_lock_ctrl.sv
// Directed and randomized checks of password_lock_ctrl against a cycle-level
// behavioural model of the lock rules.
module tb_password_lock_ctrl;

  localparam int          PW = 32;
  localparam int          MT = 3;
  localparam int          LC = 16;
  localparam logic [31:0] RP = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_op = 1'b0;
  logic [PW-1:0] cmd_data = '0;
  logic          relock = 1'b0;
  logic          unlocked;
  logic          locked_out;
  logic          resp_valid;
  logic          resp_ok;
  logic [1:0]    fail_count;

  password_lock_ctrl #(
    .PASS_WIDTH(PW), .MAX_TRIES(MT), .LOCKOUT_CYCLES(LC), .RESET_PASS(RP)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .relock(relock),
    .unlocked(unlocked), .locked_out(locked_out), .resp_valid(resp_valid),
    .resp_ok(resp_ok), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: door open flag, stored password, failure tally and
  // remaining lockout cycles (0 means not in lockout).
  logic [31:0] m_pass;
  bit          m_open;
  int          m_fails;
  int          m_left;
  bit          e_rv;
  bit          e_ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pass = RP; m_open = 0; m_fails = 0; m_left = 0; e_rv = 0; e_ok = 0;
  endtask

  task automatic model_step(input bit v, input bit op, input logic [31:0] d, input bit rl);
    e_rv = 0; e_ok = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_fails = 0;
    end else if (m_open) begin
      if (v) begin
        e_rv = 1;
        if (op) begin m_pass = d; e_ok = 1; end
        else e_ok = (d == m_pass);
      end
      if (rl) m_open = 0;
    end else if (v) begin
      e_rv = 1;
      if (!op) begin
        if (d == m_pass) begin m_open = 1; m_fails = 0; e_ok = 1; end
        else begin
          if (m_fails < MT) m_fails++;
          if (m_fails >= MT) m_left = LC;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".unlocked"},   32'(unlocked),   32'(m_open));
    chk({tag, ".locked_out"}, 32'(locked_out), 32'(m_left > 0));
    chk({tag, ".cmd_ready"},  32'(cmd_ready),  32'(m_left == 0));
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(e_rv));
    chk({tag, ".fail_count"}, 32'(fail_count), 32'(m_fails));
    if (e_rv) chk({tag, ".resp_ok"}, 32'(resp_ok), 32'(e_ok));
  endtask

  // Called at a negedge: drive, clock, compare, return at the next negedge.
  task automatic step(input string tag, input bit v, input bit op,
                      input logic [31:0] d, input bit rl);
    cmd_valid = v; cmd_op = op; cmd_data = d; relock = rl;
    @(posedge clk);
    model_step(v, op, d, rl);
    #1;
    check_outputs(tag);
    if (e_rv) $display("tx %s op=%0d data=%h resp_ok=%0d", tag, op, d, resp_ok);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1; cmd_valid = 0; relock = 0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int lo_cycles;
    logic [31:0] d;
    bit v, op, rl;
    int pick;

    do_reset("reset");

    // Unlock with the reset password.
    step("try_reset_pass", 1, 0, 32'h0000_0000, 0);
    step("idle", 0, 0, 32'h0, 0);

    // Set, relock, then unlock with the new password.
    step("set_deadbeef", 1, 1, 32'hDEAD_BEEF, 0);
    step("relock", 0, 0, 32'h0, 1);
    step("try_deadbeef", 1, 0, 32'hDEAD_BEEF, 0);
    step("relock2", 0, 0, 32'h0, 1);

    // Three failures lead to lockout; the correct password is driven throughout.
    step("bad1", 1, 0, 32'h1234_5678, 0);
    step("bad2", 1, 0, 32'h1234_5678, 0);
    step("bad3", 1, 0, 32'h1234_5678, 0);
    lo_cycles = 0;
    while (locked_out === 1'b1 && lo_cycles < 40) begin
      lo_cycles++;
      step("lockout_try", 1, 0, 32'hDEAD_BEEF, 0);
    end
    chk("lockout_dwell", 32'(lo_cycles), 32'(LC));
    step("post_lockout_try", 1, 0, 32'hDEAD_BEEF, 0);
    step("relock3", 0, 0, 32'h0, 1);

    // Set while locked is rejected; old password still works.
    step("locked_set", 1, 1, 32'hCAFE_F00D, 0);
    step("try_old", 1, 0, 32'hDEAD_BEEF, 0);

    // Set with simultaneous relock.
    step("set_relock", 1, 1, 32'h0000_ABCD, 1);
    step("try_abcd", 1, 0, 32'h0000_ABCD, 0);
    step("relock4", 0, 0, 32'h0, 1);

    // Reset in the middle of a lockout.
    step("mbad1", 1, 0, 32'h1111_1111, 0);
    step("mbad2", 1, 0, 32'h1111_1111, 0);
    step("mbad3", 1, 0, 32'h1111_1111, 0);
    step("mid_lockout", 0, 0, 32'h0, 0);
    step("mid_lockout2", 0, 0, 32'h0, 0);
    #2;
    do_reset("reset_mid_lockout");
    step("try_abcd_after_rst", 1, 0, 32'h0000_ABCD, 0);
    step("try_rp_after_rst", 1, 0, RP, 0);

    // Randomized traffic with a small password pool so matches are frequent.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2;
        do_reset("rand_reset");
      end
      v    = ($urandom_range(0, 3) != 0);
      op   = ($urandom_range(0, 3) == 0);
      rl   = ($urandom_range(0, 7) == 0);
      pick = $urandom_range(0, 3);
      case (pick)
        0:       d = m_pass;
        1:       d = RP;
        2:       d = 32'hDEAD_BEEF;
        default: d = $urandom;
      endcase
      step("rand", v, op, d, rl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
